ps2_mouse_ctrl: RTL and testbench

Protocol-level PS/2 mouse controller. It sits between a byte-level PS/2 transceiver (single-cycle read/err strobes and a write request) and the user logic. It initialises the mouse, then decodes stream-mode movement packets. It maintains clamped absolute cursor coordinates, button states and a per-packet event strobe, with runtime-programmable coordinate bounds.

---
 rtl/ps2_mouse_if.sv | 31 +++
 rtl/ps2_mouse_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_ps2_mouse_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_mouse_if.sv
// Bundle between the PS/2 mouse controller, its byte transceiver and user logic.
// master drives strobes and programming inputs; slave is the controller.
interface ps2_mouse_if;
    logic       read;
    logic       write;
    logic       err;
    logic       setmax_x;
    logic       setmax_y;
    logic       setx;
    logic       sety;
    logic [9:0] value;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic       left;
    logic       middle;
    logic       right;
    logic [9:0] xpos;
    logic [9:0] ypos;
    logic [3:0] zpos;
    logic       new_event;

    modport master (
        output read, err, setmax_x, setmax_y, setx, sety, value, rx_data,
        input  write, tx_data, left, middle, right, xpos, ypos, zpos, new_event
    );

    modport slave (
        input  read, err, setmax_x, setmax_y, setx, sety, value, rx_data,
        output write, tx_data, left, middle, right, xpos, ypos, zpos, new_event
    );
endinterface

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse protocol controller: init sequence, stream packet decode, clamped cursor.
// Define MOUSE_WHEEL_EN to enable the IntelliMouse wheel handshake and 4-byte packets.
module ps2_mouse_ctrl #(
    parameter logic [9:0] MAX_X_RST   = 10'd640,
    parameter logic [9:0] MAX_Y_RST   = 10'd480,
    parameter logic [7:0] SAMPLE_RATE = 8'h28
) (
    input  logic       clk,
    input  logic       rst,
    ps2_mouse_if.slave bus
);
    localparam logic [3:0] RST_SEND  = 4'd0;
    localparam logic [3:0] RST_ACK   = 4'd1;
    localparam logic [3:0] RST_BAT   = 4'd2;
    localparam logic [3:0] RST_ID    = 4'd3;
    localparam logic [3:0] SR_SEND   = 4'd4;
    localparam logic [3:0] SR_ACK    = 4'd5;
    localparam logic [3:0] RATE_SEND = 4'd6;
    localparam logic [3:0] RATE_ACK  = 4'd7;
    localparam logic [3:0] EN_SEND   = 4'd8;
    localparam logic [3:0] EN_ACK    = 4'd9;
    localparam logic [3:0] STREAM    = 4'd10;
`ifdef MOUSE_WHEEL_EN
    localparam logic [3:0] ID_SEND   = 4'd11;
    localparam logic [3:0] ID_ACK    = 4'd12;
    localparam logic [3:0] ID_READ   = 4'd13;
    localparam logic [1:0] LAST_RATE = 2'd3;
    localparam logic [3:0] POST_RATE = ID_SEND;
`else
    localparam logic [3:0] LAST_RATE_PAD = 4'd0;
    localparam logic [1:0] LAST_RATE = LAST_RATE_PAD[1:0];
    localparam logic [3:0] POST_RATE = EN_SEND;
`endif

    logic [3:0] state;
    logic [1:0] rate_cnt;
    logic [1:0] idx;
    logic [6:0] b0_r;      // {yov, xov, ysign, xsign, middle, right, left}
    logic [7:0] dx_r, dy_r;
    logic       wheel_mode;
    logic       write_r;
    logic [7:0] tx_r;
    logic [9:0] max_x_r, max_y_r, xpos_r, ypos_r;
    logic       left_r, middle_r, right_r, evt_r;

    // The rate table is walked in order; only entry 0 is used without the wheel.
    function automatic logic [7:0] rate_byte(input logic [1:0] i);
        case (i)
            2'd1:    rate_byte = 8'd200;
            2'd2:    rate_byte = 8'd100;
            2'd3:    rate_byte = 8'd80;
            default: rate_byte = SAMPLE_RATE;
        endcase
    endfunction

    function automatic logic [9:0] clamp(input logic signed [11:0] v, input logic [9:0] m);
        if (m == 10'd0 || v[11])                  clamp = 10'd0;
        else if (v >= $signed({2'b00, m}))         clamp = m - 10'd1;
        else                                       clamp = v[9:0];
    endfunction

    logic               pkt_done;
    logic [7:0]         dy_byte;
    logic signed [11:0] dx12, dy12, x_sum, y_sum;
    logic [9:0]         x_nxt, y_nxt;

    assign pkt_done = (state == STREAM) && bus.read && !bus.err &&
                      (idx == (wheel_mode ? 2'd3 : 2'd2));
    assign dy_byte  = wheel_mode ? dy_r : bus.rx_data;
    assign dx12     = b0_r[5] ? 12'sd0 : $signed({{4{b0_r[3]}}, dx_r});
    assign dy12     = b0_r[6] ? 12'sd0 : $signed({{4{b0_r[4]}}, dy_byte});
    assign x_sum    = $signed({2'b00, xpos_r}) + dx12;
    assign y_sum    = $signed({2'b00, ypos_r}) - dy12;

    // Programming inputs take precedence over a coincident packet on their axis.
    always_comb begin
        x_nxt = xpos_r;
        if (bus.setx)
            x_nxt = clamp({2'b00, bus.value}, bus.setmax_x ? bus.value : max_x_r);
        else if (bus.setmax_x)
            x_nxt = clamp({2'b00, xpos_r}, bus.value);
        else if (pkt_done)
            x_nxt = clamp(x_sum, max_x_r);
    end

    always_comb begin
        y_nxt = ypos_r;
        if (bus.sety)
            y_nxt = clamp({2'b00, bus.value}, bus.setmax_y ? bus.value : max_y_r);
        else if (bus.setmax_y)
            y_nxt = clamp({2'b00, ypos_r}, bus.value);
        else if (pkt_done)
            y_nxt = clamp(y_sum, max_y_r);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RST_SEND;
            rate_cnt <= 2'd0;
            idx      <= 2'd0;
            b0_r     <= 7'd0;
            dx_r     <= 8'd0;
            dy_r     <= 8'd0;
            write_r  <= 1'b0;
            tx_r     <= 8'd0;
`ifdef MOUSE_WHEEL_EN
            wheel_mode <= 1'b0;
`endif
        end else begin
            write_r <= 1'b0;
            if (state != STREAM && bus.err) begin
                state <= RST_SEND;
            end else begin
                case (state)
                    RST_SEND: begin
                        write_r  <= 1'b1;
                        tx_r     <= 8'hFF;
                        rate_cnt <= 2'd0;
`ifdef MOUSE_WHEEL_EN
                        wheel_mode <= 1'b0;
`endif
                        state    <= RST_ACK;
                    end
                    RST_ACK: if (bus.read) state <= (bus.rx_data == 8'hFA) ? RST_BAT : RST_SEND;
                    RST_BAT: if (bus.read) state <= (bus.rx_data == 8'hAA) ? RST_ID  : RST_SEND;
                    RST_ID:  if (bus.read) state <= (bus.rx_data == 8'h00) ? SR_SEND : RST_SEND;
                    SR_SEND: begin
                        write_r <= 1'b1;
                        tx_r    <= 8'hF3;
                        state   <= SR_ACK;
                    end
                    SR_ACK: if (bus.read) state <= (bus.rx_data == 8'hFA) ? RATE_SEND : RST_SEND;
                    RATE_SEND: begin
                        write_r <= 1'b1;
                        tx_r    <= rate_byte(rate_cnt);
                        state   <= RATE_ACK;
                    end
                    RATE_ACK: if (bus.read) begin
                        if (bus.rx_data != 8'hFA)     state <= RST_SEND;
                        else if (rate_cnt == LAST_RATE) state <= POST_RATE;
                        else begin
                            rate_cnt <= rate_cnt + 2'd1;
                            state    <= SR_SEND;
                        end
                    end
`ifdef MOUSE_WHEEL_EN
                    ID_SEND: begin
                        write_r <= 1'b1;
                        tx_r    <= 8'hF2;
                        state   <= ID_ACK;
                    end
                    ID_ACK: if (bus.read) state <= (bus.rx_data == 8'hFA) ? ID_READ : RST_SEND;
                    ID_READ: if (bus.read) begin
                        if (bus.rx_data == 8'h03 || bus.rx_data == 8'h00) begin
                            wheel_mode <= bus.rx_data[0];
                            state      <= EN_SEND;
                        end else begin
                            state <= RST_SEND;
                        end
                    end
`endif
                    EN_SEND: begin
                        write_r <= 1'b1;
                        tx_r    <= 8'hF4;
                        state   <= EN_ACK;
                    end
                    EN_ACK: if (bus.read) begin
                        idx   <= 2'd0;
                        state <= (bus.rx_data == 8'hFA) ? STREAM : RST_SEND;
                    end
                    STREAM: begin
                        if (bus.err) begin
                            idx <= 2'd0;
                        end else if (bus.read) begin
                            case (idx)
                                2'd0: if (bus.rx_data[3]) begin
                                    b0_r <= {bus.rx_data[7:4], bus.rx_data[2:0]};
                                    idx  <= 2'd1;
                                end
                                2'd1: begin
                                    dx_r <= bus.rx_data;
                                    idx  <= 2'd2;
                                end
                                2'd2: begin
                                    dy_r <= bus.rx_data;
                                    idx  <= wheel_mode ? 2'd3 : 2'd0;
                                end
                                default: idx <= 2'd0;
                            endcase
                        end
                    end
                    default: state <= RST_SEND;
                endcase
            end
        end
    end

`ifndef MOUSE_WHEEL_EN
    assign wheel_mode = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_x_r  <= MAX_X_RST;
            max_y_r  <= MAX_Y_RST;
            xpos_r   <= 10'd0;
            ypos_r   <= 10'd0;
            left_r   <= 1'b0;
            middle_r <= 1'b0;
            right_r  <= 1'b0;
            evt_r    <= 1'b0;
        end else begin
            if (bus.setmax_x) max_x_r <= bus.value;
            if (bus.setmax_y) max_y_r <= bus.value;
            xpos_r <= x_nxt;
            ypos_r <= y_nxt;
            evt_r  <= pkt_done;
            if (pkt_done) begin
                left_r   <= b0_r[0];
                right_r  <= b0_r[1];
                middle_r <= b0_r[2];
            end
        end
    end

`ifdef MOUSE_WHEEL_EN
    logic [3:0] zpos_r;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        zpos_r <= 4'd0;
        else if (pkt_done && wheel_mode) zpos_r <= zpos_r + bus.rx_data[3:0];
    end
    assign bus.zpos = zpos_r;
`else
    assign bus.zpos = 4'd0;
`endif

    assign bus.write     = write_r;
    assign bus.tx_data   = tx_r;
    assign bus.left      = left_r;
    assign bus.middle    = middle_r;
    assign bus.right     = right_r;
    assign bus.xpos      = xpos_r;
    assign bus.ypos      = ypos_r;
    assign bus.new_event = evt_r;
endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Scoreboard bench for ps2_mouse_ctrl: directed plan items plus randomized packets
// and programming ops, checked against an integer cursor model.
module tb_ps2_mouse_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_mouse_if bus();
    ps2_mouse_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic       l, m, r;
        logic [9:0] x, y;
    } evt_t;

    logic [7:0] exp_tx[$];
    evt_t       exp_evt[$];
    int checks = 0;
    int failures = 0;
    int mx = 640, my = 480, px = 0, py = 0;
    logic prev_w = 1'b0, prev_e = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int clampi(input int v, input int m);
        if (m == 0 || v < 0) return 0;
        if (v >= m) return m - 1;
        return v;
    endfunction

    // Monitor: compares every write pulse and every event against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.write) begin
                check("write_width", int'(prev_w), 0);
                check("write_expected", int'(exp_tx.size() > 0), 1);
                if (exp_tx.size() > 0) check("tx_data", bus.tx_data, exp_tx.pop_front());
            end
            if (bus.new_event) begin
                check("event_width", int'(prev_e), 0);
                check("event_expected", int'(exp_evt.size() > 0), 1);
                if (exp_evt.size() > 0) begin
                    evt_t e;
                    e = exp_evt.pop_front();
                    check("evt_left", bus.left, e.l);
                    check("evt_middle", bus.middle, e.m);
                    check("evt_right", bus.right, e.r);
                    check("evt_xpos", bus.xpos, e.x);
                    check("evt_ypos", bus.ypos, e.y);
                    check("evt_zpos", bus.zpos, 0);
                end
            end
            prev_w = bus.write;
            prev_e = bus.new_event;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.read = 1'b1;
        bus.rx_data = b;
        tick();
        bus.read = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_write();
        int n = 0;
        while (!bus.write && n < 50) begin
            tick();
            n++;
        end
        check("write_timeout", int'(n < 50), 1);
        tick();
    endtask

    task automatic do_init(input logic fault);
        exp_tx.push_back(8'hFF);
        wait_write();
        if (fault) begin
            exp_tx.push_back(8'hFF);
            send_byte(8'hFE, 0);
            wait_write();
        end
        send_byte(8'hFA, 1);
        send_byte(8'hAA, 2);
        exp_tx.push_back(8'hF3);
        send_byte(8'h00, 0);
        wait_write();
        exp_tx.push_back(8'h28);
        send_byte(8'hFA, 0);
        wait_write();
        exp_tx.push_back(8'hF4);
        send_byte(8'hFA, 0);
        wait_write();
        send_byte(8'hFA, 2);
    endtask

    task automatic send_pkt(input logic [7:0] b0, b1, b2, input logic set_last, input logic [9:0] sv);
        int dx, dy;
        evt_t e;
        dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
        dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
        px = set_last ? clampi(int'(sv), mx) : clampi(px + dx, mx);
        py = clampi(py - dy, my);
        e.l = b0[0]; e.r = b0[1]; e.m = b0[2];
        e.x = 10'(px); e.y = 10'(py);
        exp_evt.push_back(e);
        send_byte(b0, $urandom_range(0, 2));
        send_byte(b1, $urandom_range(0, 2));
        if (set_last) begin
            bus.setx = 1'b1;
            bus.value = sv;
        end
        bus.read = 1'b1;
        bus.rx_data = b2;
        tick();
        bus.read = 1'b0;
        bus.setx = 1'b0;
        repeat (2) tick();
    endtask

    task automatic do_set(input int which, input logic [9:0] v);
        bus.value = v;
        case (which)
            0: begin bus.setmax_x = 1'b1; mx = int'(v); px = clampi(px, mx); end
            1: begin bus.setmax_y = 1'b1; my = int'(v); py = clampi(py, my); end
            2: begin bus.setx = 1'b1; px = clampi(int'(v), mx); end
            default: begin bus.sety = 1'b1; py = clampi(int'(v), my); end
        endcase
        tick();
        bus.setmax_x = 1'b0; bus.setmax_y = 1'b0; bus.setx = 1'b0; bus.sety = 1'b0;
        check("set_xpos", bus.xpos, px);
        check("set_ypos", bus.ypos, py);
    endtask

    task automatic err_pulse();
        bus.err = 1'b1;
        tick();
        bus.err = 1'b0;
    endtask

    function automatic logic [7:0] rnd_b0();
        logic [7:0] b;
        b = 8'($urandom);
        b[3] = 1'b1;
        b[6] = ($urandom_range(0, 7) == 0);
        b[7] = ($urandom_range(0, 7) == 0);
        return b;
    endfunction

    initial begin
        bus.read = 0; bus.err = 0; bus.setmax_x = 0; bus.setmax_y = 0;
        bus.setx = 0; bus.sety = 0; bus.value = '0; bus.rx_data = '0;
        repeat (2) tick();
        check("rst_write", bus.write, 0);
        check("rst_tx", bus.tx_data, 0);
        check("rst_xpos", bus.xpos, 0);
        check("rst_ypos", bus.ypos, 0);
        check("rst_zpos", bus.zpos, 0);
        check("rst_buttons", {bus.left, bus.middle, bus.right}, 0);
        check("rst_event", bus.new_event, 0);
        rst = 1'b0;

        do_init(1'b0);

        send_pkt(8'h09, 8'h05, 8'h03, 1'b0, '0);
        check("tp2_left", bus.left, 1);
        check("tp2_xpos", bus.xpos, 5);
        check("tp2_ypos", bus.ypos, 0);

        do_set(0, 10'd360);
        do_set(2, 10'd350);
        send_pkt(8'h08, 8'h20, 8'h00, 1'b0, '0);
        check("tp3_clamp", bus.xpos, 359);
        send_pkt(8'h18, 8'h80, 8'h00, 1'b0, '0);
        check("tp3_neg", bus.xpos, 231);

        send_byte(8'h00, 1);
        send_pkt(8'h08, 8'h01, 8'h01, 1'b0, '0);
        check("tp4_xpos", bus.xpos, 232);
        check("tp4_ypos", bus.ypos, 0);

        send_byte(8'h08, 0);
        send_byte(8'h05, 0);
        err_pulse();
        send_pkt(8'h08, 8'h02, 8'h00, 1'b0, '0);
        check("tp5_xpos", bus.xpos, 234);

        do_set(3, 10'd100);
        send_pkt(8'h0A, 8'h10, 8'h05, 1'b1, 10'd7);
        check("set_wins_x", bus.xpos, 7);
        check("set_wins_y", bus.ypos, 95);

        for (int i = 0; i < 150; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                do_set($urandom_range(0, 3), 10'($urandom_range(0, 1023)));
            end else if (r == 2) begin
                send_byte(8'($urandom) & 8'hF7, $urandom_range(0, 2));
                send_pkt(rnd_b0(), 8'($urandom), 8'($urandom), 1'b0, '0);
            end else if (r == 3) begin
                send_byte(rnd_b0(), 0);
                send_byte(8'($urandom), 0);
                err_pulse();
                send_pkt(rnd_b0(), 8'($urandom), 8'($urandom), 1'b0, '0);
            end else begin
                send_pkt(rnd_b0(), 8'($urandom), 8'($urandom), 1'b0, '0);
            end
        end
        repeat (3) tick();
        check("evt_queue_drained", exp_evt.size(), 0);

        rst = 1'b1;
        mx = 640; my = 480; px = 0; py = 0;
        tick();
        rst = 1'b0;
        do_init(1'b1);
        send_pkt(8'h09, 8'h10, 8'h00, 1'b0, '0);
        check("pre_rst_xpos", bus.xpos, 16);
        send_byte(8'h08, 0);
        send_byte(8'h04, 0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_xpos", bus.xpos, 0);
        check("async_rst_left", bus.left, 0);
        repeat (3) tick();
        check("tx_queue_drained", exp_tx.size(), 0);
        check("evt_queue_final", exp_evt.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
